// File: rtl/ast_pkg.sv
// ---------------------------------------------------------------------------
// ast_pkg
// Shared definitions for the skewed systolic feeder:
//   - ast_state_e   : feeder FSM states (IDLE / RUN / DRAIN)
//   - ast_tile_len  : number of skewed steps in one tile, S = LANES + DEPTH - 1
// Optional feature macro used by ast_skew_feeder: AST_SKEW_ZERO_FILL_EN.
// ---------------------------------------------------------------------------
package ast_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ast_state_e;

  // Lane i is active for steps i .. i+depth-1, so the last lane finishes at
  // step (lanes-1)+(depth-1); the tile therefore spans lanes+depth-1 steps.
  function automatic int ast_tile_len(input int lanes, input int depth);
    return lanes + depth - 1;
  endfunction

endpackage

// File: rtl/ast_skew_window.sv
// ---------------------------------------------------------------------------
// ast_skew_window
// Purely combinational: given the tile step counter t, flags which lanes are
// inside their diagonal window (lane i active iff i <= t < i + DEPTH).
// Ports:
//   t_i       in  TW     current step counter
//   in_win_o  out LANES  per-lane in-window flags
// ---------------------------------------------------------------------------
module ast_skew_window
  import ast_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 8,
  parameter int TW    = $clog2(ast_tile_len(LANES, DEPTH) + 1)
) (
  input  logic [TW-1:0]    t_i,
  output logic [LANES-1:0] in_win_o
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    // Upper bound never exceeds S, which fits in TW bits by construction.
    localparam logic [TW-1:0] HI = TW'(gi + DEPTH);
    if (gi == 0) begin : g_first
      // Lower bound of lane 0 is 0, so only the upper bound matters.
      assign in_win_o[gi] = (t_i < HI);
    end else begin : g_rest
      localparam logic [TW-1:0] LO = TW'(gi);
      assign in_win_o[gi] = (t_i >= LO) && (t_i < HI);
    end
  end

endmodule

// File: rtl/ast_skew_feeder.sv
// ---------------------------------------------------------------------------
// ast_skew_feeder
// Drains one tile from LANES upstream parallel-load FIFOs into a systolic
// array with a one-cycle diagonal skew per lane. Any in-window lane running
// empty stalls the whole tile so the skew alignment is never broken.
// Ports:
//   clk         in   1                 clock, rising edge
//   rst         in   1                 synchronous active-high reset
//   start       in   1                 tile-drain request (IDLE only)
//   lane_empty  in   LANES             upstream FIFO empty flags
//   lane_data   in   LANES*DATAWIDTH   upstream registered data_out (lane i at [i*DW +: DW])
//   lane_pop    out  LANES             pop strobes, combinational
//   out_valid   out  LANES             element valid, registered (pop delayed 1)
//   out_data    out  LANES*DATAWIDTH   element data to the array
//   busy        out  1                 FSM not idle
//   done        out  1                 one-cycle pulse at end of tile
// Optional feature: define AST_SKEW_ZERO_FILL_EN to force out_data lanes to
// zero whenever their out_valid is low.
// ---------------------------------------------------------------------------
module ast_skew_feeder
  import ast_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DEPTH     = 8,
  parameter int DATAWIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [LANES-1:0]           lane_empty,
  input  logic [LANES*DATAWIDTH-1:0] lane_data,
  output logic [LANES-1:0]           lane_pop,
  output logic [LANES-1:0]           out_valid,
  output logic [LANES*DATAWIDTH-1:0] out_data,
  output logic                       busy,
  output logic                       done
);

  localparam int S  = ast_tile_len(LANES, DEPTH);
  localparam int TW = $clog2(S + 1);
  localparam logic [TW-1:0] T_LAST = TW'(S - 1);

  ast_state_e       state_q, state_d;
  logic [TW-1:0]    t_q, t_d;
  logic [LANES-1:0] out_valid_q;
  logic [LANES-1:0] in_win;
  logic [LANES-1:0] pop_d;
  logic             stall;

  ast_skew_window #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .TW    (TW)
  ) u_window (
    .t_i      (t_q),
    .in_win_o (in_win)
  );

  // One empty in-window lane freezes every lane, keeping the diagonal intact.
  assign stall = (state_q == RUN) && ((in_win & lane_empty) != '0);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    pop_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          pop_d = in_win;
          if (t_q == T_LAST) begin
            state_d = DRAIN;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      out_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      // Upstream FIFO presents popped data one cycle later.
      out_valid_q <= pop_d;
    end
  end

  // Reset masks the combinational outputs in the same cycle it is asserted.
  assign lane_pop  = rst ? '0 : pop_d;
  assign busy      = !rst && (state_q != IDLE);
  assign done      = !rst && (state_q == DRAIN);
  assign out_valid = out_valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_out
`ifdef AST_SKEW_ZERO_FILL_EN
    assign out_data[gi*DATAWIDTH +: DATAWIDTH] =
      out_valid_q[gi] ? lane_data[gi*DATAWIDTH +: DATAWIDTH] : '0;
`else
    assign out_data[gi*DATAWIDTH +: DATAWIDTH] = lane_data[gi*DATAWIDTH +: DATAWIDTH];
`endif
  end

endmodule

// File: tb/tb_ast_skew_feeder.sv
// ---------------------------------------------------------------------------
// tb_ast_skew_feeder
// Directed tiles (clean, stalled, reset-aborted, start held high) followed by
// randomized start/empty/reset traffic, all compared cycle by cycle against a
// step-based reference model plus an upstream FIFO model that feeds lane i
// with 16*i+k for its k-th pop.
// ---------------------------------------------------------------------------
module tb_ast_skew_feeder;

  localparam int LANES = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int S     = LANES + DEPTH - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [LANES-1:0]      lane_empty;
  logic [LANES*DW-1:0]   lane_data;
  logic [LANES-1:0]      lane_pop;
  logic [LANES-1:0]      out_valid;
  logic [LANES*DW-1:0]   out_data;
  logic                  busy;
  logic                  done;

  always #5 clk = ~clk;

  ast_skew_feeder #(
    .LANES     (LANES),
    .DEPTH     (DEPTH),
    .DATAWIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .lane_empty (lane_empty),
    .lane_data  (lane_data),
    .lane_pop   (lane_pop),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: tile in progress, draining, current step.
  bit               m_busy  = 1'b0;
  bit               m_drain = 1'b0;
  int               m_t     = 0;
  logic [LANES-1:0] m_valid = '0;
  int               vcnt[LANES];
  int               popcnt[LANES];
  int               tile_cyc = 0;

  // DUT-observed tile timing.
  int abs_cyc   = 0;
  int rise_cyc  = 0;
  int done_at   = -1;
  bit busy_prev = 1'b0;
  int rise_list[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, abs_cyc, got, exp);
    end
  endtask

  task automatic step();
    logic [LANES-1:0] win;
    logic [LANES-1:0] exp_pop;
    logic [LANES-1:0] dut_pop;
    logic [DW-1:0]    ed;
    bit               run;
    bit               stall;
    @(negedge clk);
    run = m_busy && !m_drain;
    for (int i = 0; i < LANES; i++) win[i] = (m_t >= i) && (m_t < i + DEPTH);
    stall   = run && ((win & lane_empty) != '0);
    exp_pop = (!rst && run && !stall) ? win : '0;
    check("lane_pop", lane_pop, exp_pop);
    check("out_valid", out_valid, m_valid);
    check("done", done, !rst && m_drain);
    check("busy", busy, !rst && m_busy);
    for (int i = 0; i < LANES; i++) begin
      if (m_valid[i]) ed = DW'(16 * i + vcnt[i]);
      else begin
`ifdef AST_SKEW_ZERO_FILL_EN
        ed = '0;
`else
        ed = lane_data[i*DW +: DW];
`endif
      end
      check("out_data", out_data[i*DW +: DW], ed);
      if (m_valid[i]) vcnt[i]++;
    end
    if (!rst && m_drain)
      for (int i = 0; i < LANES; i++) check("valid_cnt", vcnt[i], DEPTH);
    if (busy && !busy_prev) begin
      rise_cyc = abs_cyc;
      rise_list.push_back(abs_cyc);
    end
    if (done) begin
      done_at = abs_cyc - rise_cyc + 1;
      $display("tile complete: done in tile cycle %0d (abs cycle %0d)", done_at, abs_cyc);
    end
    busy_prev = busy;
    dut_pop   = lane_pop;
    @(posedge clk);
    abs_cyc++;
    if (rst) begin
      m_busy = 0; m_drain = 0; m_t = 0; m_valid = '0; tile_cyc = 0;
    end else begin
      m_valid = exp_pop;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_t = 0; tile_cyc = 1;
          for (int i = 0; i < LANES; i++) begin vcnt[i] = 0; popcnt[i] = 0; end
        end
      end else if (m_drain) begin
        m_busy = 0; m_drain = 0; tile_cyc = 0;
      end else begin
        tile_cyc++;
        if (!stall) begin
          if (m_t == S - 1) m_drain = 1;
          else m_t++;
        end
      end
    end
    // Upstream FIFO: registered data_out updates on the popping edge.
    for (int i = 0; i < LANES; i++) begin
      if (dut_pop[i]) begin
        lane_data[i*DW +: DW] = DW'(16 * i + popcnt[i]);
        popcnt[i]++;
      end
    end
    if (!m_busy) lane_data = {LANES{8'hAA}};
    #1;
  endtask

  initial begin
    int gap;
    logic [DW-1:0] idle_exp;
    for (int i = 0; i < LANES; i++) begin vcnt[i] = 0; popcnt[i] = 0; end
    rst = 1'b1; start = 1'b0; lane_empty = '0; lane_data = {LANES{8'hAA}};
    repeat (3) step();
    rst = 1'b0;
    step();

    // Clean tile: done in cycle 12.
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    repeat (16) step();
    check("t1_done_cycle", done_at, 12);

    // Lane 2 empty in tile cycles 5..7: done slips to cycle 15.
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      lane_empty = (tile_cyc >= 5 && tile_cyc <= 7) ? 4'b0100 : 4'b0000;
      step();
    end
    lane_empty = '0;
    check("t2_done_cycle", done_at, 15);

    // Reset in tile cycle 6 aborts without done; next tile is clean.
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rst = (tile_cyc == 6);
      step();
    end
    rst = 1'b0;
    check("t3_abort_no_done", done_at, -1);
    done_at = -1;
    start = 1'b1; step(); start = 1'b0;
    repeat (16) step();
    check("t3_restart_done_cycle", done_at, 12);

    // Start held through cycles 0..13: second tile begins in cycle 14.
    rise_list.delete();
    start = 1'b1;
    repeat (14) step();
    start = 1'b0;
    repeat (16) step();
    check("t4_tile_count", rise_list.size(), 2);
    gap = (rise_list.size() >= 2) ? rise_list[1] - rise_list[0] : -1;
    check("t4_second_start", gap, 13);

    // Idle with lane_data at AA.
    repeat (2) step();
`ifdef AST_SKEW_ZERO_FILL_EN
    idle_exp = 8'h00;
`else
    idle_exp = 8'hAA;
`endif
    check("idle_fill", out_data[DW-1:0], idle_exp);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(99) < 2);
      start = ($urandom_range(99) < 30);
      for (int i = 0; i < LANES; i++) lane_empty[i] = ($urandom_range(99) < 15);
      step();
    end
    rst = 1'b0; start = 1'b0; lane_empty = '0;
    repeat (20) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ast_skew_feeder.md
AST_SKEW_FEEDER -- requirements
Module: ast_skew_feeder

Interface
REQ-001 Parameter LANES, default 4: number of upstream parallel-load FIFOs and systolic rows fed.
REQ-002 Parameter DEPTH, default 8: elements drained per lane per tile; equals upstream FIFO depth.
REQ-003 Parameter DATAWIDTH, default 8: element width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  tile-drain request; sampled only in IDLE.
REQ-007 lane_empty  in  LANES  per-lane empty flag from upstream FIFO.
REQ-008 lane_data  in  LANES x DATAWIDTH  per-lane registered data_out from upstream FIFO.
REQ-009 lane_pop  out  LANES  per-lane pop strobe to upstream FIFO; combinational.
REQ-010 out_valid  out  LANES  per-lane element-valid to the systolic array; registered.
REQ-011 out_data  out  LANES x DATAWIDTH  per-lane element to the systolic array.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  single-cycle pulse when a tile has fully drained.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-015 IDLE->RUN on start=1; start while busy is ignored and not queued.
REQ-016 Step counter t SHALL clear to 0 on RUN entry; tile length S = DEPTH+LANES-1 steps (0..S-1); counter width clog2(S+1).
REQ-017 Lane i is in-window at step t iff i <= t < i+DEPTH, giving one-cycle diagonal skew per lane.
REQ-018 stall SHALL equal RUN AND any in-window lane with lane_empty=1.
REQ-019 lane_pop[i] = RUN AND in-window(i) AND NOT stall; outside RUN all pops are 0.
REQ-020 On stall, t SHALL hold and no lane pops, preserving skew alignment across lanes.
REQ-021 t increments by 1 per non-stalled RUN cycle; RUN->DRAIN on the non-stalled cycle with t=S-1.
REQ-022 out_valid[i] SHALL be lane_pop[i] delayed one cycle, matching upstream registered read latency.
REQ-023 out_data[i] SHALL pass lane_data[i] through combinationally when out_valid[i]=1.
REQ-024 DRAIN lasts exactly one cycle, asserts done=1, then returns to IDLE.
REQ-025 start asserted in the DRAIN cycle SHALL be ignored; a new tile needs start in IDLE.

Reset
REQ-026 On rst: state=IDLE, t=0, out_valid=0, done=0, busy=0, lane_pop=0 in the same cycle.
REQ-027 rst mid-RUN or mid-DRAIN SHALL abort the tile without done; no pops issue while rst=1.
REQ-028 rst has priority over start and stall.

Configuration
REQ-029 Macro AST_SKEW_ZERO_FILL_EN: when defined, out_data[i] SHALL be 0 whenever out_valid[i]=0.
REQ-030 Without AST_SKEW_ZERO_FILL_EN, out_data[i] = lane_data[i] unconditionally; consumers qualify with out_valid.

Structure
REQ-031 Shared package ast_pkg SHALL hold the FSM state enum (IDLE/RUN/DRAIN) and a function returning S from LANES and DEPTH.
REQ-032 One sub-module ast_skew_window SHALL compute the per-lane in-window vector from t, LANES and DEPTH; all sequential logic stays in ast_skew_feeder.

Verification (LANES=4, DEPTH=8, DATAWIDTH=8; cycle 1 = first cycle after the edge sampling start)
REQ-033 All lanes non-empty, start pulse -> lane_pop[0] cycles 1-8, lane_pop[3] cycles 4-11; out_valid[0] cycles 2-9, out_valid[3] cycles 5-12; done=1 only in cycle 12; busy cycles 1-12.
REQ-034 Lane 2 empty for 3 cycles starting cycle 5 -> all lane_pop=0 in cycles 5-7, t holds at 4, done moves to cycle 15, per-lane valid counts still 8 each.
REQ-035 Lane i FIFO preloaded with values 16*i+k, k=0..7 -> out_data[i] emits 16*i..16*i+7 in order, starting exactly i cycles after lane 0.
REQ-036 rst asserted in cycle 6 -> lane_pop and out_valid 0 from the next cycle, no done, busy=0; a following start yields the full REQ-033 sequence.
REQ-037 start held high through cycles 1-13 -> no extra pops during RUN/DRAIN; a second tile begins in cycle 14 (start sampled in IDLE cycle 13).
REQ-038 With AST_SKEW_ZERO_FILL_EN, lane_data held at 8'hAA while idle -> out_data=0; without it, out_data=8'hAA.
